// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU result FIFO: default result width, default
// depth, stored entry width, the offsets of the three flag bits above the
// result field in a stored entry, and the per-cycle FIFO operation encoding.
// ---------------------------------------------------------------------------
package alu_pkg;

  // Default sign-magnitude result width (sign at ALU_RW-1).
  localparam int ALU_RW    = 4;
  // Default number of FIFO entries (2, 4 or 8).
  localparam int ALU_DEPTH = 4;
  // Stored entry is {DZF, zerF, negF, Res}.
  localparam int ENTRY_W   = ALU_RW + 3;

  // Flag positions relative to the top of the result field.
  localparam int NEGF_OFS  = 0;
  localparam int ZERF_OFS  = 1;
  localparam int DZF_OFS   = 2;

  // Absolute bit index of a flag in an entry whose result field is rw bits.
  function automatic int flag_idx(input int rw, input int ofs);
    return rw + ofs;
  endfunction

  // What the FIFO does on a given edge, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/alu_result_fifo_if.sv
// ---------------------------------------------------------------------------
// alu_result_fifo_if
// Handshake bundle between the ALU stage, the result FIFO and its consumer.
//   Upstream  : in_valid, in_ready, Res, negF, zerF, DZF
//   Downstream: out_valid, out_ready, OutRes, OutNegF, OutZerF, OutDZF
// Modports:
//   slave  - the FIFO side (accepts upstream results, presents the head)
//   master - the environment side (drives results, consumes the head)
// ---------------------------------------------------------------------------
interface alu_result_fifo_if
  import alu_pkg::*;
#(
  parameter int RW = ALU_RW
) ();

  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] Res;
  logic          negF;
  logic          zerF;
  logic          DZF;

  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] OutRes;
  logic          OutNegF;
  logic          OutZerF;
  logic          OutDZF;

  modport slave (
    input  in_valid, Res, negF, zerF, DZF, out_ready,
    output in_ready, out_valid, OutRes, OutNegF, OutZerF, OutDZF
  );

  modport master (
    output in_valid, Res, negF, zerF, DZF, out_ready,
    input  in_ready, out_valid, OutRes, OutNegF, OutZerF, OutDZF
  );

endinterface

// File: rtl/alu_fifo_mem.sv
// ---------------------------------------------------------------------------
// alu_fifo_mem
// Circular storage for the result FIFO: DEPTH entries of W bits with write
// and read pointers. The caller decides when a write or read is legal; this
// block only stores and advances.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (pointers only)
//   wr_en      - store wr_data at the write pointer and advance it
//   wr_data    - entry to store
//   rd_en      - advance the read pointer (head entry consumed)
//   rd_data    - entry at the read pointer (current head)
// ---------------------------------------------------------------------------
module alu_fifo_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = ALU_DEPTH,
  parameter int W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // DEPTH is a power of two, so the natural roll-over of an AW-bit pointer
  // is exactly the modulo-DEPTH wrap.
  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // NOTE: the storage array has no reset; stale words are never observable
  // because the owner masks the head while the FIFO is empty, and leaving it
  // unreset lets it map onto plain register-file cells.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
// Buffers sign-magnitude ALU results with their flags. On entry the flags are
// made self-consistent (divide-by-zero clears everything else; a zero
// magnitude means zero and never negative). Sticky DZF/neg status and a
// saturating divide-by-zero counter track accepted entries.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   bus         - alu_result_fifo_if.slave: in_valid/in_ready/Res/negF/zerF/DZF
//                 upstream, out_valid/out_ready/OutRes/OutNegF/OutZerF/OutDZF
//                 downstream
//   clr_sticky  - synchronous clear of StickyDZF, StickyNegF and DzCnt
//   count       - number of stored entries (0..DEPTH)
//   StickyDZF   - set by any accepted entry carrying DZF
//   StickyNegF  - set by any accepted entry carrying negF (after sanitising)
//   DzCnt       - count of accepted DZF entries, saturating at 15
// ---------------------------------------------------------------------------
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = ALU_DEPTH,
  parameter int RW    = ALU_RW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_result_fifo_if.slave         bus,
  input  logic                     clr_sticky,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     StickyDZF,
  output logic                     StickyNegF,
  output logic [3:0]               DzCnt
);

  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int EW       = RW + 3;
  localparam int NEGF_IDX = flag_idx(RW, NEGF_OFS);
  localparam int ZERF_IDX = flag_idx(RW, ZERF_OFS);
  localparam int DZF_IDX  = flag_idx(RW, DZF_OFS);

  logic          push;
  logic          pop;
  fifo_op_e      op;
  logic          mag_zero;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head_raw;
  logic [EW-1:0] head;
  logic          sticky_dzf_next;
  logic          sticky_neg_next;
  logic [3:0]    dz_base;
  logic [3:0]    dz_cnt_next;

  // Handshake: both flags depend on stored state only, so a full FIFO never
  // accepts even when the consumer pops in the same cycle.
  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid  && bus.in_ready;
  assign pop           = bus.out_ready && bus.out_valid;
  assign op            = fifo_op_e'({push, pop});

  // Sanitise the incoming result before it is stored.
  assign mag_zero = (bus.Res[RW-2:0] == '0);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    wr_entry = '0;
    if (bus.DZF) begin
      wr_entry[DZF_IDX] = 1'b1;
    end else begin
      wr_entry[RW-1:0]  = bus.Res;
      wr_entry[ZERF_IDX] = mag_zero | bus.zerF;
      wr_entry[NEGF_IDX] = ~mag_zero & bus.negF;
    end
  end

  alu_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head_raw)
  );

  // The head is masked while empty so unreset storage never leaks out, and
  // the outputs fall to zero as soon as reset clears count.
  assign head        = bus.out_valid ? head_raw : '0;
  assign bus.OutRes  = head[RW-1:0];
  assign bus.OutNegF = head[NEGF_IDX];
  assign bus.OutZerF = head[ZERF_IDX];
  assign bus.OutDZF  = head[DZF_IDX];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      unique case (op)
        OP_PUSH: count <= count + CW'(1);
        OP_POP:  count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Clear first, then add this edge's push: a push coinciding with
  // clr_sticky still leaves its own contribution behind.
  always_comb begin
    dz_base         = clr_sticky ? 4'd0 : DzCnt;
    sticky_dzf_next = clr_sticky ? 1'b0 : StickyDZF;
    sticky_neg_next = clr_sticky ? 1'b0 : StickyNegF;
    dz_cnt_next     = dz_base;
    if (push) begin
      sticky_dzf_next = sticky_dzf_next | wr_entry[DZF_IDX];
      sticky_neg_next = sticky_neg_next | wr_entry[NEGF_IDX];
      if (wr_entry[DZF_IDX] && (dz_base != 4'd15)) begin
        dz_cnt_next = dz_base + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StickyDZF  <= 1'b0;
      StickyNegF <= 1'b0;
      DzCnt      <= 4'd0;
    end else begin
      StickyDZF  <= sticky_dzf_next;
      StickyNegF <= sticky_neg_next;
      DzCnt      <= dz_cnt_next;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_alu_result_fifo
// Self-checking bench for alu_result_fifo (DEPTH=4, RW=4). A queue-based
// reference model tracks the stored entries and sticky status; directed
// scenarios also check fixed expected values.
// ---------------------------------------------------------------------------
module tb_alu_result_fifo;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int RW    = 4;

  typedef struct packed {
    logic          dz;
    logic          zer;
    logic          neg;
    logic [RW-1:0] res;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_sticky;
  logic [2:0] count;
  logic       StickyDZF;
  logic       StickyNegF;
  logic [3:0] DzCnt;

  alu_result_fifo_if #(.RW(RW)) bus ();

  alu_result_fifo #(
    .DEPTH (DEPTH),
    .RW    (RW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_sticky (clr_sticky),
    .count      (count),
    .StickyDZF  (StickyDZF),
    .StickyNegF (StickyNegF),
    .DzCnt      (DzCnt)
  );

  always #5 clk = ~clk;

  // Reference model state.
  ent_t q[$];
  logic m_sdz;
  logic m_sneg;
  int   m_dzcnt;

  int checks = 0;
  int errors = 0;

  // Flag rules for an accepted result.
  function automatic ent_t sanitize(input logic [RW-1:0] r, input logic n,
                                    input logic z, input logic d);
    ent_t e;
    if (d) begin
      e = '{dz: 1'b1, zer: 1'b0, neg: 1'b0, res: '0};
    end else if (r[RW-2:0] == 0) begin
      e = '{dz: 1'b0, zer: 1'b1, neg: 1'b0, res: r};
    end else begin
      e = '{dz: 1'b0, zer: z, neg: n, res: r};
    end
    return e;
  endfunction

  // {out_valid, in_ready, count, OutDZF, OutZerF, OutNegF, OutRes,
  //  StickyDZF, StickyNegF, DzCnt}
  function automatic logic [17:0] model_vec();
    ent_t h;
    h = (q.size() > 0) ? q[0] : '0;
    return {q.size() > 0, q.size() < DEPTH, 3'(q.size()),
            h.dz, h.zer, h.neg, h.res, m_sdz, m_sneg, 4'(m_dzcnt)};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {bus.out_valid, bus.in_ready, count, bus.OutDZF, bus.OutZerF,
            bus.OutNegF, bus.OutRes, StickyDZF, StickyNegF, DzCnt};
  endfunction

  task automatic model_reset();
    q.delete();
    m_sdz   = 1'b0;
    m_sneg  = 1'b0;
    m_dzcnt = 0;
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, and return
  // 1 ns after the edge with outputs settled.
  task automatic cycle(input logic iv, input logic [RW-1:0] r, input logic n,
                       input logic z, input logic d, input logic ordy,
                       input logic clr);
    logic do_push;
    logic do_pop;
    ent_t e;
    bus.in_valid  = iv;
    bus.Res       = r;
    bus.negF      = n;
    bus.zerF      = z;
    bus.DZF       = d;
    bus.out_ready = ordy;
    clr_sticky    = clr;
    do_push = iv && (q.size() < DEPTH);
    do_pop  = ordy && (q.size() > 0);
    e = sanitize(r, n, z, d);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(e);
    if (clr) begin
      m_sdz   = 1'b0;
      m_sneg  = 1'b0;
      m_dzcnt = 0;
    end
    if (do_push) begin
      m_sdz  = m_sdz | e.dz;
      m_sneg = m_sneg | e.neg;
      if (e.dz && m_dzcnt < 15) m_dzcnt++;
    end
    #1;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    model_reset();
    checks++;
    if (dut_vec() !== 18'b0_1_000_0_0_0_0000_0_0_0000) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", dut_vec(),
               18'b0_1_000_0_0_0_0000_0_0_0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_cycle();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL reset_idle: got %b want %b", dut_vec(), model_vec());
    end
  endtask

  task automatic test_single();
    cycle(1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({bus.out_valid, bus.OutRes, bus.OutNegF, bus.OutZerF, count} !==
        {1'b1, 4'b0101, 1'b1, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL single_push: got v=%b res=%b neg=%b zer=%b cnt=%0d want 1 0101 1 0 1",
               bus.out_valid, bus.OutRes, bus.OutNegF, bus.OutZerF, count);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL single_model: got %b want %b", dut_vec(), model_vec());
    end
    drain();
  endtask

  task automatic test_neg_zero();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({bus.OutZerF, bus.OutNegF, StickyNegF, bus.OutRes} !==
        {1'b1, 1'b0, 1'b0, 4'b1000}) begin
      errors++;
      $display("FAIL neg_zero: got zer=%b neg=%b sticky_neg=%b res=%b want 1 0 0 1000",
               bus.OutZerF, bus.OutNegF, StickyNegF, bus.OutRes);
    end
    drain();
  endtask

  task automatic test_dzf();
    cycle(1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({bus.OutRes, bus.OutNegF, bus.OutZerF, bus.OutDZF, StickyDZF, DzCnt} !==
        {4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL dzf_push: got res=%b neg=%b zer=%b dz=%b sdz=%b cnt=%0d want 0000 0 0 1 1 1",
               bus.OutRes, bus.OutNegF, bus.OutZerF, bus.OutDZF, StickyDZF, DzCnt);
    end
    drain();
  endtask

  task automatic test_full();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if ({bus.in_ready, count} !== {1'b0, 3'd4}) begin
      errors++;
      $display("FAIL full_flags: got ready=%b cnt=%0d want 0 4", bus.in_ready, count);
    end
    cycle(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd4 || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL full_ignore: got %b want %b", dut_vec(), model_vec());
    end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (bus.OutRes !== 4'(i) || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL full_order_%0d: got v=%b res=%b want 1 %b", i, bus.out_valid,
                 bus.OutRes, 4'(i));
      end
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if ({bus.out_valid, count, bus.OutRes} !== {1'b0, 3'd0, 4'd0}) begin
      errors++;
      $display("FAIL full_empty: got v=%b cnt=%0d res=%b want 0 0 0000",
               bus.out_valid, count, bus.OutRes);
    end
    // Pop while empty is ignored.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL empty_pop: got %b want %b", dut_vec(), model_vec());
    end
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.OutRes !== 4'b0011) begin
      errors++;
      $display("FAIL simul_head: got %b want 0011", bus.OutRes);
    end
    cycle(1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({count, bus.OutRes} !== {3'd2, 4'b0110}) begin
      errors++;
      $display("FAIL simul_count: got cnt=%0d head=%b want 2 0110", count, bus.OutRes);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({count, bus.OutRes} !== {3'd1, 4'b0111}) begin
      errors++;
      $display("FAIL simul_last: got cnt=%0d head=%b want 1 0111", count, bus.OutRes);
    end
    drain();
  endtask

  task automatic test_dz_saturate();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 4'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b0);
    end
    checks++;
    if ({DzCnt, StickyDZF} !== {4'd15, 1'b1}) begin
      errors++;
      $display("FAIL dz_saturate: got cnt=%0d sdz=%b want 15 1", DzCnt, StickyDZF);
    end
    cycle(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({DzCnt, StickyDZF} !== {4'd1, 1'b1}) begin
      errors++;
      $display("FAIL clr_with_push: got cnt=%0d sdz=%b want 1 1", DzCnt, StickyDZF);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({DzCnt, StickyDZF, StickyNegF} !== {4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clr_only: got cnt=%0d sdz=%b sneg=%b want 0 0 0",
               DzCnt, StickyDZF, StickyNegF);
    end
    drain();
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (dut_vec() !== model_vec() || count !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset: got %b want %b", dut_vec(), model_vec());
    end
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({count, bus.out_valid, bus.OutRes, DzCnt} !== {3'd0, 1'b0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL async_reset: got cnt=%0d v=%b res=%b dzcnt=%0d want 0 0 0000 0",
               count, bus.out_valid, bus.OutRes, DzCnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_cycle();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL post_reset: got %b want %b", dut_vec(), model_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 15) == 0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random_%0d: got %b want %b", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.Res       = '0;
    bus.negF      = 1'b0;
    bus.zerF      = 1'b0;
    bus.DZF       = 1'b0;
    bus.out_ready = 1'b0;
    clr_sticky    = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_neg_zero();
    test_dzf();
    test_full();
    test_simultaneous();
    test_dz_saturate();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of result entries; legal values are 2, 4 and 8.
REQ-002 The block SHALL have parameter RW, default 4, meaning the result width (sign bit at RW-1, magnitude below).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream ALU result/flags valid this cycle.
REQ-006 in_ready  output  1  block can accept a result this cycle.
REQ-007 Res  input  RW  sign-magnitude result from the ALU stage.
REQ-008 negF, zerF, DZF  input  1 each  negative, zero and divide-by-zero flags accompanying Res.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_ready  input  1  consumer takes the head entry this cycle.
REQ-011 OutRes  output  RW  head-entry result.
REQ-012 OutNegF, OutZerF, OutDZF  output  1 each  head-entry flags.
REQ-013 count  output  log2(DEPTH)+1  number of stored entries.
REQ-014 clr_sticky  input  1  synchronous clear of sticky status.
REQ-015 StickyDZF, StickyNegF  output  1 each  sticky flags, set by any accepted entry carrying that flag.
REQ-016 DzCnt  output  4  saturating count of accepted DZF entries.

Function
REQ-017 Push SHALL occur on the clk edge where in_valid && in_ready; pop SHALL occur on the edge where out_valid && out_ready.
REQ-018 in_ready SHALL equal (count != DEPTH), combinational from state only; there is no same-cycle pass-through when full.
REQ-019 out_valid SHALL equal (count != 0); OutRes and the Out* flags SHALL be driven from the head storage entry.
REQ-020 Latency SHALL be one cycle: a push into an empty FIFO gives out_valid=1 on the following cycle.
REQ-021 Each entry SHALL store {DZF, zerF, negF, Res} (RW+3 bits); entries SHALL be delivered in push order.
REQ-022 If DZF=1 on push, the stored Res, negF and zerF SHALL be forced to 0; the stored DZF SHALL be 1.
REQ-023 If DZF=0 and the Res magnitude is 0, the stored negF SHALL be 0 and the stored zerF SHALL be 1, regardless of the inputs.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 count SHALL increment on push-only, decrement on pop-only, and hold on simultaneous push and pop (legal only when 0<count<DEPTH).
REQ-026 in_valid while full SHALL be ignored: no state change, and the upstream holds its data.
REQ-027 out_ready while empty SHALL be ignored.
REQ-028 The sticky flags and DzCnt SHALL update only on an accepted push and SHALL use the sanitized flags.
REQ-029 DzCnt SHALL saturate at 15 and never wrap.
REQ-030 clr_sticky SHALL zero StickyDZF, StickyNegF and DzCnt on the next edge; if it coincides with a push, the cleared state plus that push's contribution SHALL result (set wins, DzCnt becomes 0 or 1).

Reset
REQ-031 While rst_n=0, asynchronously: pointers=0, count=0, out_valid=0, OutRes=0, all Out* flags=0, sticky flags=0, DzCnt=0, in_ready=1.
REQ-032 A reset mid-operation SHALL discard all stored entries; storage contents need not be cleared, but outputs SHALL read 0 while empty.

Structure
REQ-033 A shared package alu_pkg SHALL hold RW, the default DEPTH, the entry width and the field bit indices (DZF, zerF, negF).
REQ-034 The storage array with its pointers SHALL be the single sub-module alu_fifo_mem; the sanitizing, handshake and sticky logic SHALL stay in alu_result_fifo.

Verification
REQ-035 Push Res=0101, negF=1, DZF=0 into an empty FIFO -> next cycle out_valid=1, OutRes=0101, OutNegF=1, OutZerF=0, count=1.
REQ-036 Push Res=1011 with DZF=1 -> OutRes=0000, OutNegF=0, OutZerF=0, OutDZF=1, StickyDZF=1, DzCnt=1.
REQ-037 Push 4 entries with out_ready=0 (DEPTH=4) -> in_ready=0 and count=4; a 5th in_valid is ignored; pops then return entries 1..4 in order.
REQ-038 At count=2, push and pop in the same cycle -> count stays 2, the popped value is the oldest entry, and the new entry is delivered last.
REQ-039 Push 17 entries with DZF=1 while draining -> DzCnt=15; clr_sticky together with a DZF push -> DzCnt=1, StickyDZF=1.
REQ-040 Push Res=1000 (negative zero) with negF=1 and zerF=0 -> OutZerF=1, OutNegF=0, StickyNegF unchanged.
REQ-041 Assert rst_n=0 mid-cycle at count=3 -> count=0, out_valid=0, OutRes=0 and DzCnt=0 immediately, before the next clk edge.
